// File: rtl/lsu_sequencer.sv
// lsu_sequencer
// Multi-cycle load/store sequencer between the core and a handshaked data
// memory. A request carries a 6-bit load/store code (lb..sw), an effective byte
// address and store data. It becomes one aligned 32-bit memory transaction with
// byte enables, and the core is stalled until that transaction completes.
// Loads return sign- or zero-extended data. Misaligned accesses finish with
// err=01 and never reach memory.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a memory request with
// err=10 once TIMEOUT_CYCLES cycles have passed without mem_ready.
//
// Ports
//   clk, rst                   rising-edge clock; asynchronous active-high reset
//   start, ctrl_code           request strobe (sampled in IDLE only) and code
//   addr, store_data           effective byte address, rs2 value
//   mem_req/we/addr/be/wdata   memory request, held stable while waiting
//   mem_rdata, mem_ready       memory response; completes on the sampled edge
//   stall                      hold the core this cycle
//   done, load_data, err       one-cycle completion pulse with result/status
module lsu_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        ctrl_code,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic [1:0]        err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] DONE_S = 2'd2;

    localparam logic [5:0] C_LB  = 6'b010011;
    localparam logic [5:0] C_LH  = 6'b010100;
    localparam logic [5:0] C_LW  = 6'b010101;
    localparam logic [5:0] C_LBU = 6'b010110;
    localparam logic [5:0] C_LHU = 6'b010111;
    localparam logic [5:0] C_SB  = 6'b011000;
    localparam logic [5:0] C_SH  = 6'b011001;
    localparam logic [5:0] C_SW  = 6'b011010;

    logic [1:0]  state_reg;
    logic [5:0]  code_reg;
    logic [1:0]  off_reg;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]  wait_cnt_reg;
`endif

    // Decode of the incoming request
    logic        code_valid;
    logic        code_store;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    always_comb begin
        code_valid = (ctrl_code >= C_LB) && (ctrl_code <= C_SW);
        code_store = (ctrl_code == C_SB) || (ctrl_code == C_SH) || (ctrl_code == C_SW);
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (ctrl_code)
            C_LH, C_LHU: misaligned = addr[0];
            C_LW:        misaligned = (addr[1:0] != 2'b00);
            C_SB: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            C_SH: begin
                misaligned = addr[0];
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
            end
            C_SW:    misaligned = (addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    // Load extraction from the returning word, using the latched code/offset
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        byte_sel = mem_rdata[{off_reg, 3'b000} +: 8];
        half_sel = mem_rdata[{off_reg[1], 4'b0000} +: 16];
        case (code_reg)
            C_LB:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            C_LBU:   load_ext = {24'd0, byte_sel};
            C_LH:    load_ext = {{16{half_sel[15]}}, half_sel};
            C_LHU:   load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    logic code_reg_store;
    assign code_reg_store = (code_reg == C_SB) || (code_reg == C_SH) || (code_reg == C_SW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            code_reg     <= 6'd0;
            off_reg      <= 2'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            load_data    <= 32'd0;
            err          <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_reg <= 8'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && code_valid) begin
                        code_reg <= ctrl_code;
                        off_reg  <= addr[1:0];
                        if (misaligned) begin
                            err       <= 2'b01;
                            state_reg <= DONE_S;
                        end else begin
                            mem_we       <= code_store;
                            mem_addr     <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be       <= be_next;
                            mem_wdata    <= wdata_next;
                            state_reg    <= REQ;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt_reg <= 8'd0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!code_reg_store) begin
                            load_data <= load_ext;
                        end
                        err       <= 2'b00;
                        state_reg <= DONE_S;
                    end
`ifdef LSU_TIMEOUT_EN
                    // This cycle is the TIMEOUT_CYCLES-th one without mem_ready.
                    else if (int'(wait_cnt_reg) + 1 >= TIMEOUT_CYCLES) begin
                        err       <= 2'b10;
                        state_reg <= DONE_S;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end
                DONE_S:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req = (state_reg == REQ);
    assign done    = (state_reg == DONE_S);
    assign stall   = ((state_reg == IDLE) && start && code_valid) || (state_reg == REQ);

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer
// Directed load/store vectors for lsu_sequencer. The driver pushes expected
// completions and memory transactions into queues; independent monitors pop
// and compare when the DUT shows done or a completing memory handshake.
module tb_lsu_sequencer;

    localparam logic [5:0] LB  = 6'b010011;
    localparam logic [5:0] LH  = 6'b010100;
    localparam logic [5:0] LW  = 6'b010101;
    localparam logic [5:0] LBU = 6'b010110;
    localparam logic [5:0] LHU = 6'b010111;
    localparam logic [5:0] SB  = 6'b011000;
    localparam logic [5:0] SH  = 6'b011001;
    localparam logic [5:0] SW  = 6'b011010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  ctrl_code = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  err;

    lsu_sequencer #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl_code(ctrl_code),
        .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .done(done), .load_data(load_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic [1:0]  err;
        int          dcyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic        chk_wd;
    } mem_t;

    exp_t sb[$];
    mem_t mq[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   resp_wait = 0;
    logic [31:0] resp_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory model: answers resp_wait cycles after mem_req first appears.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req) begin
                if (wcnt >= resp_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_rdata;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("load_data", load_data, e.ld);
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", cyc, e.dcyc);
                chk("stall_on_done", 32'(stall), 32'd0);
            end
        end
    end

    // Memory bus monitor: request fields must match the expected transaction
    // on every cycle mem_req is high, popping only on the completing cycle.
    always @(negedge clk) begin
        if (!rst && mem_req) begin
            if (mq.size() == 0) begin
                chk("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else begin
                chk("mem_addr", mem_addr, mq[0].addr);
                chk("mem_be", 32'(mem_be), 32'(mq[0].be));
                chk("mem_we", 32'(mem_we), 32'(mq[0].we));
                if (mq[0].chk_wd) chk("mem_wdata", mem_wdata, mq[0].wd);
                if (mem_ready) void'(mq.pop_front());
            end
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL completion_wait: got no done within %0d cycles, expected done", n);
            sb.delete();
            mq.delete();
        end
    endtask

    task automatic do_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int wt, input logic expm,
                         input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic ewe, input logic chkwd, input logic [31:0] eld,
                         input logic [1:0] eerr, input int lat, input logic hold2);
        exp_t e;
        mem_t m;
        @(posedge clk); #1;
        resp_wait  = wt;
        resp_rdata = rd;
        start = 1'b1; ctrl_code = code; addr = a; store_data = sd;
        e.ld = eld; e.err = eerr; e.dcyc = cyc + lat;
        sb.push_back(e);
        if (expm) begin
            m.addr = ea; m.be = ebe; m.wd = ewd; m.we = ewe; m.chk_wd = chkwd;
            mq.push_back(m);
        end
        #3 chk("stall_on_start", 32'(stall), 32'd1);
        @(posedge clk); #1;
        if (hold2) begin
            // Request still asserted while the sequencer is in DONE: ignored.
            #3 chk("stall_in_done", 32'(stall), 32'd0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_empty();
    endtask

    initial begin
        #12 rst = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        //     code a            sd            rd            wt mem  ea            be       wd            we   cwd  eld           err    lat hold
        do_op(LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b1, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 2'b00, 2, 1'b0);
        do_op(LB,  32'h103, 32'h0,        32'h80FF0000, 0, 1'b1, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 2'b00, 2, 1'b0);
        do_op(LBU, 32'h103, 32'h0,        32'h80FF0000, 0, 1'b1, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h00000080, 2'b00, 2, 1'b0);
        do_op(SH,  32'h202, 32'h1234ABCD, 32'h0,        3, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1, 1'b1, 32'h00000080, 2'b00, 5, 1'b0);
        do_op(SW,  32'h301, 32'h0,        32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h00000080, 2'b01, 1, 1'b0);
        do_op(LH,  32'h102, 32'h0,        32'h80011234, 0, 1'b1, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hFFFF8001, 2'b00, 2, 1'b0);
        do_op(LHU, 32'h100, 32'h0,        32'h8001F234, 1, 1'b1, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0000F234, 2'b00, 3, 1'b0);
        do_op(LH,  32'h101, 32'h0,        32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0000F234, 2'b01, 1, 1'b0);
        do_op(LB,  32'h101, 32'h0,        32'h00007F00, 0, 1'b1, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0000007F, 2'b00, 2, 1'b0);
        do_op(SB,  32'h102, 32'h000000A5, 32'h0,        1, 1'b1, 32'h100, 4'b0100, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h0000007F, 2'b00, 3, 1'b0);
        do_op(SH,  32'h200, 32'h1234ABCD, 32'h0,        0, 1'b1, 32'h200, 4'b0011, 32'hABCDABCD, 1'b1, 1'b1, 32'h0000007F, 2'b00, 2, 1'b0);
        do_op(SW,  32'h304, 32'hCAFEF00D, 32'h0,        2, 1'b1, 32'h304, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0000007F, 2'b00, 4, 1'b0);
        do_op(LW,  32'h106, 32'h0,        32'h0,        0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0000007F, 2'b01, 1, 1'b1);

        // Codes outside lb..sw are ignored.
        @(posedge clk); #1;
        start = 1'b1; ctrl_code = 6'b000000; addr = 32'h100;
        #3 chk("invalid_code_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ctrl_code = 6'b011011;
        #3 chk("invalid_code_stall2", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #3 chk("invalid_code_no_req", 32'(mem_req), 32'd0);
        chk("invalid_code_no_done", 32'(done), 32'd0);

        // Asynchronous reset in the second REQ cycle of a load.
        begin
            mem_t m;
            @(posedge clk); #1;
            resp_wait = 5; resp_rdata = 32'h0;
            start = 1'b1; ctrl_code = LW; addr = 32'h500;
            m.addr = 32'h500; m.be = 4'b1111; m.wd = 32'h0; m.we = 1'b0; m.chk_wd = 1'b0;
            mq.push_back(m);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #2;
            rst = 1'b1;
            #1;
            chk("arst_mem_req", 32'(mem_req), 32'd0);
            chk("arst_stall", 32'(stall), 32'd0);
            chk("arst_done", 32'(done), 32'd0);
            chk("arst_mem_addr", mem_addr, 32'd0);
            chk("arst_mem_be", 32'(mem_be), 32'd0);
            chk("arst_mem_wdata", mem_wdata, 32'd0);
            chk("arst_mem_we", 32'(mem_we), 32'd0);
            chk("arst_load_data", load_data, 32'd0);
            chk("arst_err", 32'(err), 32'd0);
            #1 rst = 1'b0;
            mq.delete();
        end
        do_op(LW, 32'h400, 32'h0, 32'h12345678, 0, 1'b1, 32'h400, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h12345678, 2'b00, 2, 1'b0);

`ifdef LSU_TIMEOUT_EN
        // Memory never answers: four REQ cycles, then abort with err=10.
        do_op(LW, 32'h600, 32'h0, 32'h0, 1000, 1'b1, 32'h600, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h12345678, 2'b10, 5, 1'b0);
        chk("timeout_req_dropped", 32'(mem_req), 32'd0);
        mq.delete();
`else
        // Memory never answers: the request is held indefinitely.
        begin
            mem_t m;
            @(posedge clk); #1;
            resp_wait = 1000;
            start = 1'b1; ctrl_code = LW; addr = 32'h600;
            m.addr = 32'h600; m.be = 4'b1111; m.wd = 32'h0; m.we = 1'b0; m.chk_wd = 1'b0;
            mq.push_back(m);
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk); #1;
                chk("no_timeout_req_held", 32'(mem_req), 32'd1);
            end
            rst = 1'b1;
            #1 chk("no_timeout_rst_req", 32'(mem_req), 32'd0);
            #1 rst = 1'b0;
            mq.delete();
        end
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
